pmem_responder: RTL and testbench

- Line-granular physical-memory responder: the far end of the cache's pmem_* interface. It accepts 128-bit line reads and writes from the cache controller/datapath and answers each with a one-cycle pmem_resp after a fixed latency.
- Backs a synthesizable line array covering the LC-3b address space.
- Used as the memory endpoint in the cache subsystem and as the reference memory in cache benches.

---
 rtl/lc3b_types.sv | 15 +
 rtl/pmem_line_array.sv | 26 ++
 rtl/pmem_responder.sv | 161 ++++++++++++++++
 tb/tb_pmem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/line types plus physical-memory responder state and line size
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_pmem_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } lc3b_pmem_state;

    localparam int PMEM_LINE_BYTES = 16;

endpackage

// File: rtl/pmem_line_array.sv
// rtl/pmem_line_array.sv - single-port 128-bit line store with synchronous write and combinational read
module pmem_line_array #(
    parameter int INDEX_BITS = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] widx,
    input  logic [127:0]          wdata,
    input  logic [INDEX_BITS-1:0] ridx,
    output logic [127:0]          rdata
);

    // Line storage; contents deliberately survive reset.
    logic [127:0] mem_q [2**INDEX_BITS];

    // Commit a line on the write-enable edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    // Read port is purely combinational so the responder sees the line in the same cycle.
    assign rdata = mem_q[ridx];

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency line memory endpoint for the cache pmem_* interface (optional PMEM_STATS_EN)
module pmem_responder #(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
`ifdef PMEM_STATS_EN
    output logic [15:0]  read_count,
    output logic [15:0]  write_count,
`endif
    output logic         protocol_err
);

    import lc3b_types::*;

    // Cycles spent in BUSY are LATENCY-1; the counter reaches zero in the last of them.
    localparam logic [7:0]  CNT_LOAD  = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;
    localparam logic [15:0] ADDR_USED = 16'(((1 << INDEX_BITS) - 1) << 4);

    lc3b_pmem_state        state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    lc3b_pmem_line         wdata_q, wdata_d;
    logic                  op_write_q, op_write_d;
    lc3b_pmem_line         rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  mem_we;
    lc3b_pmem_line         arr_rdata;
    logic                  req;
    logic                  addr_unused;

`ifdef PMEM_STATS_EN
    logic [15:0]           read_count_q, read_count_d;
    logic [15:0]           write_count_q, write_count_d;
`endif

    assign req         = pmem_read | pmem_write;
    // Offset bits and any index bits beyond INDEX_BITS are don't-care (aliasing allowed).
    assign addr_unused = ^(pmem_address & ~ADDR_USED);

    pmem_line_array #(
        .INDEX_BITS(INDEX_BITS)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .widx (idx_q),
        .wdata(wdata_q),
        .ridx (idx_q),
        .rdata(arr_rdata)
    );

    // Next-state, capture, error and commit logic for the three-state handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        op_write_d = op_write_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d      = pmem_address[INDEX_BITS+3:4];
                    wdata_d    = pmem_wdata;
                    op_write_d = pmem_write;
                    cnt_d      = CNT_LOAD;
                    if (pmem_read && pmem_write) begin
                        err_d = 1'b1;
                    end
                    state_d = (LATENCY == 1) ? RESPOND : BUSY;
                end
            end
            BUSY: begin
                if (!req) begin
                    err_d = 1'b1;
                end
                if (cnt_q == 8'd0) begin
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
                if (op_write_q) begin
                    mem_we = 1'b1;
                end else begin
                    rdata_d = arr_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data is live from the array during a read's RESPOND cycle, then held.
    assign pmem_rdata   = (state_q == RESPOND && !op_write_q) ? arr_rdata : rdata_q;
    assign pmem_resp    = (state_q == RESPOND);
    assign protocol_err = err_q;

    // Control and capture registers; an in-flight transaction is abandoned on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            idx_q      <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            op_write_q <= op_write_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

`ifdef PMEM_STATS_EN
    // Saturating per-op completion counters, bumped on the RESPOND cycle.
    always_comb begin
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        if (state_q == RESPOND) begin
            if (op_write_q) begin
                if (write_count_q != 16'hFFFF) write_count_d = write_count_q + 16'd1;
            end else begin
                if (read_count_q != 16'hFFFF) read_count_d = read_count_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_count_q  <= 16'd0;
            write_count_q <= 16'd0;
        end else begin
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
        end
    end

    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - directed self-checking bench for pmem_responder at LATENCY 4 and 1
module tb_pmem_responder;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         a_read, a_write;
    logic [15:0]  a_addr;
    logic [127:0] a_wdata, a_rdata;
    logic         a_resp, a_err;

    logic         b_read, b_write;
    logic [15:0]  b_addr;
    logic [127:0] b_wdata, b_rdata;
    logic         b_resp, b_err;

`ifdef PMEM_STATS_EN
    logic [15:0]  a_rcnt, a_wcnt, b_rcnt, b_wcnt;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int a_resp_cyc;

    localparam logic [127:0] X4   = 128'h4444_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] X2   = 128'h2222_ABCD_0000_FFFF_1234_5678_9ABC_DEF0;
    localparam logic [127:0] DEAD = 128'hDEAD_0001_0203_0405_0607_0809_0A0B_BEEF;
    localparam logic [127:0] YW   = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    localparam logic [127:0] ZW   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] B0   = 128'hB000_0000_0000_0000_0000_0000_0000_00B0;
    localparam logic [127:0] B1   = 128'hB111_1111_1111_1111_1111_1111_1111_11B1;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(4), .INDEX_BITS(12)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .pmem_read   (a_read),
        .pmem_write  (a_write),
        .pmem_address(a_addr),
        .pmem_wdata  (a_wdata),
        .pmem_rdata  (a_rdata),
        .pmem_resp   (a_resp),
`ifdef PMEM_STATS_EN
        .read_count  (a_rcnt),
        .write_count (a_wcnt),
`endif
        .protocol_err(a_err)
    );

    pmem_responder #(.LATENCY(1), .INDEX_BITS(12)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .pmem_read   (b_read),
        .pmem_write  (b_write),
        .pmem_address(b_addr),
        .pmem_wdata  (b_wdata),
        .pmem_rdata  (b_rdata),
        .pmem_resp   (b_resp),
`ifdef PMEM_STATS_EN
        .read_count  (b_rcnt),
        .write_count (b_wcnt),
`endif
        .protocol_err(b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue a request in cycle 0 and return in the cycle pmem_resp is seen (request still held).
    task automatic a_txn(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [127:0] wd, output int lat);
        step();
        a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!a_resp && lat < 20);
        a_resp_cyc = cyc;
        if (!a_resp) lat = -1;
    endtask

    task automatic a_idle();
        step();
        a_read = 1'b0; a_write = 1'b0;
    endtask

    initial begin
        int  lat;
        int  r_prev;
        logic seen;

        rst_n = 1'b0;
        a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0;
        b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0;
        dut_a.u_array.mem_q[4]  = X4;
        dut_a.u_array.mem_q[2]  = X2;
        dut_a.u_array.mem_q[3]  = 128'h0;
        dut_b.u_array.mem_q[0]  = B0;
        dut_b.u_array.mem_q[1]  = B1;
        step(); step();
        chk("reset_resp",  128'(a_resp),  128'h0);
        chk("reset_rdata", a_rdata,       128'h0);
        chk("reset_err",   128'(a_err),   128'h0);
        chk("reset_b_resp", 128'(b_resp), 128'h0);
        rst_n = 1'b1;

        // Read line 4 with latency 4.
        a_txn(1'b1, 1'b0, 16'h0040, 128'h0, lat);
        chk("rd40_latency", 128'(lat), 128'd4);
        chk("rd40_rdata",   a_rdata,   X4);
        r_prev = a_resp_cyc;

        // Back-to-back write then read-back with a different offset.
        a_txn(1'b0, 1'b1, 16'h1230, DEAD, lat);
        chk("wr_latency",  128'(lat), 128'd4);
        chk("wr_spacing",  128'(a_resp_cyc - r_prev), 128'd5);
        chk("wr_keeps_rdata", a_rdata, X4);
        r_prev = a_resp_cyc;
        a_txn(1'b1, 1'b0, 16'h123E, 128'h0, lat);
        chk("rdback_spacing", 128'(a_resp_cyc - r_prev), 128'd5);
        chk("rdback_rdata",   a_rdata, DEAD);
        a_idle();
        chk("resp_one_cycle", 128'(a_resp), 128'h0);
        chk("rdata_hold",     a_rdata, DEAD);
        chk("no_err_yet",     128'(a_err), 128'h0);

        // Dual request is a write and flags an error.
        a_txn(1'b1, 1'b1, 16'h0010, 128'h1, lat);
        chk("dual_err", 128'(a_err), 128'h1);
        a_txn(1'b1, 1'b0, 16'h0010, 128'h0, lat);
        chk("dual_rdback", a_rdata, 128'h1);
        a_idle(); step(); step();
        chk("err_sticky", 128'(a_err), 128'h1);

        // Reset in cycle 2 of a write discards it.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("err_cleared", 128'(a_err), 128'h0);
        step();
        a_write = 1'b1; a_addr = 16'h0020; a_wdata = YW;
        step(); step();
        rst_n = 1'b0; a_write = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (a_resp) seen = 1'b1;
            step();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (a_resp) seen = 1'b1;
            step();
        end
        chk("rst_no_resp", 128'(seen), 128'h0);
        a_txn(1'b1, 1'b0, 16'h0020, 128'h0, lat);
        chk("rst_array_kept", a_rdata, X2);
        a_idle();

        // Request dropped during BUSY with an address change: still commits to the captured line.
        step();
        a_write = 1'b1; a_addr = 16'h0030; a_wdata = ZW;
        lat = 0;
        step(); lat++;
        step(); lat++;
        a_write = 1'b0; a_addr = 16'h0040; a_wdata = 128'h0;
        while (!a_resp && lat < 20) begin
            step(); lat++;
        end
        chk("drop_latency", 128'(lat), 128'd4);
        step();
        chk("drop_err", 128'(a_err), 128'h1);
        a_txn(1'b1, 1'b0, 16'h0030, 128'h0, lat);
        chk("drop_commit", a_rdata, ZW);
        a_txn(1'b1, 1'b0, 16'h0040, 128'h0, lat);
        chk("drop_other_line", a_rdata, X4);
        a_idle();

        // Latency 1, back-to-back reads with ignored address change while responding.
        step();
        b_read = 1'b1; b_addr = 16'h0000;
        step();
        chk("b_resp_c1",  128'(b_resp), 128'h1);
        chk("b_rdata_c1", b_rdata, B0);
        b_addr = 16'h0070;
        step();
        chk("b_resp_c2", 128'(b_resp), 128'h0);
        chk("b_hold_c2", b_rdata, B0);
        b_addr = 16'h0010;
        step();
        chk("b_resp_c3",  128'(b_resp), 128'h1);
        chk("b_rdata_c3", b_rdata, B1);
        b_read = 1'b0;
        step();
        chk("b_resp_c4", 128'(b_resp), 128'h0);

`ifdef PMEM_STATS_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        a_txn(1'b1, 1'b0, 16'h0040, 128'h0, lat);
        a_txn(1'b0, 1'b1, 16'h0050, 128'h7, lat);
        a_txn(1'b1, 1'b0, 16'h0050, 128'h0, lat);
        a_txn(1'b1, 1'b1, 16'h0060, 128'h9, lat);
        a_txn(1'b1, 1'b0, 16'h0060, 128'h0, lat);
        a_idle();
        chk("stats_reads",  128'(a_rcnt), 128'd3);
        chk("stats_writes", 128'(a_wcnt), 128'd2);
        dut_a.read_count_q = 16'hFFFE;
        a_txn(1'b1, 1'b0, 16'h0040, 128'h0, lat);
        a_txn(1'b1, 1'b0, 16'h0040, 128'h0, lat);
        a_txn(1'b1, 1'b0, 16'h0040, 128'h0, lat);
        a_idle();
        chk("stats_saturate", 128'(a_rcnt), 128'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
